vio_route_latch: RTL
====================

Name: vio_route_latch

Overview:
Per-region route controller directly upstream of the 8-region vFPGA stream switch. It produces the 14-bit route_out[i] that the switch uses as the TDEST of each user-logic (DTU) sink stream. It accepts asynchronous route updates from the control path and applies them only at packet boundaries, so TDEST stays stable for every beat of a packet. It also gates unrouted streams and counts forwarded packets per region.

Parameters:
N_ID, N_REGIONS, number of vFPGA regions / DTU streams monitored
ROUTE_BITS, 14, route/TDEST width (must match the switch TDEST width)
CNT_BITS, 16, per-region packet counter width

Ports:
aclk  in  1  single clock
aresetn  in  1  asynchronous active-low reset
cfg_valid  in  N_ID  per-region route write strobe
cfg_route  in  N_ID x ROUTE_BITS  route value to write
cfg_clear  in  N_ID  per-region route invalidate request
s_tvalid  in  N_ID  tvalid of DTU sink stream i (monitor tap)
s_tready  in  N_ID  tready of DTU sink stream i, from the switch (monitor tap)
s_tlast  in  N_ID  tlast of DTU sink stream i (monitor tap)
route_out  out  N_ID x ROUTE_BITS  active route, drives switch s_axis_tdest for DTU sinks
route_vld  out  N_ID  active route valid; the wrapper ANDs it into tvalid/tready of stream i
busy  out  N_ID  1 while region i is mid-packet or holds a pending update
pkt_cnt  out  N_ID x CNT_BITS  packets completed per region
unrouted_err  out  N_ID  sticky: tvalid seen while route_vld=0

Behaviour:
- Reset (aresetn=0, async): all outputs 0; per-region state IDLE; pend=0; pend_clr=0.
- Each region is independent. Per-region registers: route_act, act_vld, route_pend, pend, pend_clr, state {IDLE, IN_PKT}, counter.
- A beat is counted when s_tvalid & s_tready & route_vld are all 1.
- cfg_valid[i]: route_pend<=cfg_route[i]; pend<=1; pend_clr<=0. A later write overwrites an un-applied earlier one (last write wins).
- cfg_clear[i]: pend_clr<=1; pend<=0. If cfg_valid and cfg_clear are asserted in the same cycle, cfg_valid wins.
- Apply window: state==IDLE and s_tvalid[i]==0, which keeps TDEST stable while tvalid is held.
- In the apply window with pend=1: route_act<=route_pend, act_vld<=1, pend<=0. Takes effect on route_out the next cycle.
- In the apply window with pend_clr=1: act_vld<=0, pend_clr<=0. route_out holds its last value.
- A write in the same cycle as an apply is captured for the next window, not lost.
- FSM transitions:
  - IDLE -> IN_PKT on a beat with tlast=0.
  - IDLE stays IDLE on a single-beat packet (beat with tlast=1); counter+1.
  - IN_PKT -> IDLE on a beat with tlast=1; counter+1.
- No route change ever occurs in IN_PKT.
- Counter wraps at 2^CNT_BITS-1 -> 0.
- busy = (state==IN_PKT) | pend | pend_clr.
- unrouted_err[i] sets when s_tvalid=1 and act_vld=0. Cleared by cfg_valid[i]; set has priority on the same cycle.
- route_vld = act_vld (registered). All outputs are registered, zero combinational paths input->output.
- Latency: a write in cycle t on an idle, quiet region gives route_out/route_vld updated at t+2.
- Mid-packet reset: state returns to IDLE and the route is invalid. The downstream switch is reset by the same aresetn.

Decomposition:
- Shared package: ROUTE_BITS constant; route state enum (IDLE, IN_PKT).
- Sub-module vio_route_slot (one region: FSM, shadow/active registers, counter, error flag), generated N_ID times by the top.

Test Plan:
- Reset, then write route 0x3F0C to region 2 with s_tvalid low -> route_out[2]=0x3F0C and route_vld[2]=1 two cycles later; other regions stay 0.
- Region 0 mid-packet (4 beats, tlast on beat 4) with route A; write route B after beat 1 -> route_out[0]=A through beat 4, B one cycle after the tlast handshake, busy high throughout.
- Back-to-back writes 0x0010 then 0x0020 during a packet -> only 0x0020 applied after the packet; 0x0010 never appears.
- In IDLE with s_tvalid=1 and s_tready=0 for 5 cycles plus a pending write -> route_out unchanged until tvalid drops or the packet completes.
- tvalid on an unconfigured region 5 -> unrouted_err[5]=1 and sticky; a cfg_valid write clears it; a simultaneous cfg_valid and cfg_clear leaves the written route active.
- 65537 single-beat packets on region 7 -> pkt_cnt[7]=1 (wrap); assert aresetn mid-packet -> all outputs 0 immediately.

Source files
------------

// File: rtl/vio_route_latch_pkg.sv
// Shared constants and per-region route FSM state for the vFPGA route latch.
package vio_route_latch_pkg;

  localparam int N_REGIONS  = 8;
  localparam int ROUTE_BITS = 14;
  localparam int CNT_BITS   = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } route_state_t;

endpackage

// File: rtl/vio_route_latch_slot.sv
// One region: shadow/active route registers applied only at packet boundaries,
// packet FSM, packet counter and sticky unrouted-traffic flag.
module vio_route_latch_slot
  import vio_route_latch_pkg::*;
#(
  parameter int RB = ROUTE_BITS,
  parameter int CB = CNT_BITS
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          cfg_valid,
  input  logic [RB-1:0] cfg_route,
  input  logic          cfg_clear,
  input  logic          s_tvalid,
  input  logic          s_tready,
  input  logic          s_tlast,
  output logic [RB-1:0] route_out,
  output logic          route_vld,
  output logic          busy,
  output logic [CB-1:0] pkt_cnt,
  output logic          unrouted_err
);

  route_state_t  state_reg, state_next;
  logic [RB-1:0] route_act_reg, route_pend_reg;
  logic          act_vld_reg, pend_reg, pend_clr_reg, err_reg;
  logic [CB-1:0] cnt_reg;
  logic          beat, pkt_done, apply_win;

  always_comb begin
    state_next = state_reg;
    beat       = s_tvalid & s_tready & act_vld_reg;
    pkt_done   = beat & s_tlast;
    // Holding tvalid high closes the window so TDEST never moves under a waiting beat.
    apply_win  = (state_reg == IDLE) & ~s_tvalid;
    case (state_reg)
      IDLE:    if (beat && !s_tlast) state_next = IN_PKT;
      IN_PKT:  if (beat && s_tlast)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      route_act_reg  <= '0;
      route_pend_reg <= '0;
      act_vld_reg    <= 1'b0;
      pend_reg       <= 1'b0;
      pend_clr_reg   <= 1'b0;
      err_reg        <= 1'b0;
      cnt_reg        <= '0;
    end else begin
      if (pkt_done) cnt_reg <= cnt_reg + CB'(1);

      if (apply_win && pend_reg) begin
        route_act_reg <= route_pend_reg;
        act_vld_reg   <= 1'b1;
      end else if (apply_win && pend_clr_reg) begin
        act_vld_reg   <= 1'b0;
      end

      // A write landing in the apply cycle re-arms pend for the next window.
      if (cfg_valid) begin
        route_pend_reg <= cfg_route;
        pend_reg       <= 1'b1;
        pend_clr_reg   <= 1'b0;
      end else if (cfg_clear) begin
        pend_clr_reg   <= 1'b1;
        pend_reg       <= 1'b0;
      end else if (apply_win) begin
        pend_reg       <= 1'b0;
        pend_clr_reg   <= 1'b0;
      end

      if (s_tvalid && !act_vld_reg) err_reg <= 1'b1;
      else if (cfg_valid)           err_reg <= 1'b0;
    end
  end

  assign route_out    = route_act_reg;
  assign route_vld    = act_vld_reg;
  assign busy         = (state_reg == IN_PKT) | pend_reg | pend_clr_reg;
  assign pkt_cnt      = cnt_reg;
  assign unrouted_err = err_reg;

endmodule

// File: rtl/vio_route_latch.sv
// Per-region TDEST controller for the vFPGA stream switch; one slot per DTU sink.
module vio_route_latch
  import vio_route_latch_pkg::*;
#(
  parameter int N_ID = N_REGIONS,
  parameter int RB   = ROUTE_BITS,
  parameter int CB   = CNT_BITS
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [N_ID-1:0]          cfg_valid,
  input  logic [N_ID-1:0][RB-1:0]  cfg_route,
  input  logic [N_ID-1:0]          cfg_clear,
  input  logic [N_ID-1:0]          s_tvalid,
  input  logic [N_ID-1:0]          s_tready,
  input  logic [N_ID-1:0]          s_tlast,
  output logic [N_ID-1:0][RB-1:0]  route_out,
  output logic [N_ID-1:0]          route_vld,
  output logic [N_ID-1:0]          busy,
  output logic [N_ID-1:0][CB-1:0]  pkt_cnt,
  output logic [N_ID-1:0]          unrouted_err
);

  for (genvar gi = 0; gi < N_ID; gi++) begin : g_slot
    vio_route_latch_slot #(
      .RB(RB),
      .CB(CB)
    ) u_slot (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .cfg_valid    (cfg_valid[gi]),
      .cfg_route    (cfg_route[gi]),
      .cfg_clear    (cfg_clear[gi]),
      .s_tvalid     (s_tvalid[gi]),
      .s_tready     (s_tready[gi]),
      .s_tlast      (s_tlast[gi]),
      .route_out    (route_out[gi]),
      .route_vld    (route_vld[gi]),
      .busy         (busy[gi]),
      .pkt_cnt      (pkt_cnt[gi]),
      .unrouted_err (unrouted_err[gi])
    );
  end

endmodule
